// File: rtl/sram_port_arbiter.sv
// Shares one SRAM-like port between instruction fetch and load/store.
// Optional round-robin grant: define ARB_ROUND_ROBIN_EN.
module sram_port_arbiter #(
  parameter int OUT_DEPTH = 4,
  parameter int CNT_W     = 3
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             inst_req,
  input  logic             inst_wr,
  input  logic [1:0]       inst_size,
  input  logic [3:0]       inst_wstrb,
  input  logic [31:0]      inst_addr,
  input  logic [31:0]      inst_wdata,
  output logic             inst_addr_ok,
  output logic             inst_data_ok,
  output logic [31:0]      inst_rdata,
  input  logic             data_req,
  input  logic             data_wr,
  input  logic [1:0]       data_size,
  input  logic [3:0]       data_wstrb,
  input  logic [31:0]      data_addr,
  input  logic [31:0]      data_wdata,
  output logic             data_addr_ok,
  output logic             data_data_ok,
  output logic [31:0]      data_rdata,
  output logic             m_req,
  output logic             m_wr,
  output logic [1:0]       m_size,
  output logic [3:0]       m_wstrb,
  output logic [31:0]      m_addr,
  output logic [31:0]      m_wdata,
  input  logic             m_addr_ok,
  input  logic             m_data_ok,
  input  logic [31:0]      m_rdata,
  output logic [CNT_W-1:0] out_cnt,
  output logic             busy
);

  localparam int PW = $clog2(OUT_DEPTH);

  logic                 lock;
  logic                 lock_id;
  logic [OUT_DEPTH-1:0] owner_q;
  logic [PW-1:0]        wptr;
  logic [PW-1:0]        rptr;
  logic [CNT_W-1:0]     cnt;
`ifdef ARB_ROUND_ROBIN_EN
  logic                 rr_last;
`endif

  logic g_data;
  logic g_inst;
  logic sel_data;
  logic sel_inst;
  logic full;
  logic accept;
  logic resp;
  logic head;

  // Grant selection; a pending handshake pins the grant to its owner.
  always_comb begin
    g_data = 1'b0;
    g_inst = 1'b0;
    if (lock) begin
      g_data = lock_id;
      g_inst = ~lock_id;
    end else begin
`ifdef ARB_ROUND_ROBIN_EN
      if (data_req && inst_req) begin
        g_data = ~rr_last;
        g_inst = rr_last;
      end else begin
        g_data = data_req;
        g_inst = inst_req;
      end
`else
      g_data = data_req;
      g_inst = ~data_req & inst_req;
`endif
    end
  end

  assign sel_data = g_data & data_req;
  assign sel_inst = g_inst & inst_req;
  assign full     = (cnt == CNT_W'(OUT_DEPTH));

  assign m_req  = resetn & (sel_data | sel_inst) & ~full;
  assign accept = m_req & m_addr_ok;

  // Downstream request fields follow the granted requester.
  always_comb begin
    m_wr    = 1'b0;
    m_size  = 2'd0;
    m_wstrb = 4'd0;
    m_addr  = 32'd0;
    m_wdata = 32'd0;
    if (resetn && sel_data) begin
      m_wr    = data_wr;
      m_size  = data_size;
      m_wstrb = data_wstrb;
      m_addr  = data_addr;
      m_wdata = data_wdata;
    end else if (resetn && sel_inst) begin
      m_wr    = inst_wr;
      m_size  = inst_size;
      m_wstrb = inst_wstrb;
      m_addr  = inst_addr;
      m_wdata = inst_wdata;
    end
  end

  assign inst_addr_ok = accept & sel_inst;
  assign data_addr_ok = accept & sel_data;

  assign head = owner_q[rptr];
  assign resp = resetn & m_data_ok & (cnt != '0);

  assign inst_data_ok = resp & ~head;
  assign data_data_ok = resp & head;
  assign inst_rdata   = resetn ? m_rdata : 32'd0;
  assign data_rdata   = resetn ? m_rdata : 32'd0;

  assign out_cnt = cnt;
  assign busy    = (cnt != '0) | lock;

  // Hold the grant while a request waits for its address handshake.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock    <= 1'b0;
      lock_id <= 1'b0;
    end else if (m_req && !m_addr_ok) begin
      lock    <= 1'b1;
      lock_id <= sel_data;
    end else begin
      lock    <= 1'b0;
    end
  end

  // In-order owner FIFO: push on accept, pop on each response.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      owner_q <= '0;
      wptr    <= '0;
      rptr    <= '0;
      cnt     <= '0;
    end else begin
      if (accept) begin
        owner_q[wptr] <= sel_data;
        wptr          <= wptr + 1'b1;
      end
      if (resp) begin
        rptr <= rptr + 1'b1;
      end
      if (accept && !resp) begin
        cnt <= cnt + 1'b1;
      end else if (!accept && resp) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Remember who won the last accept for alternating grants.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rr_last <= 1'b0;
    end else if (accept) begin
      rr_last <= sel_data;
    end
  end
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter.
// Scoreboard queue holds expected responses; monitor checks strobes.
module tb_sram_port_arbiter;

  logic        clk;
  logic        resetn;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [3:0]  inst_wstrb;
  logic [31:0] inst_addr, inst_wdata;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        m_req, m_wr;
  logic [1:0]  m_size;
  logic [3:0]  m_wstrb;
  logic [31:0] m_addr, m_wdata;
  logic        m_addr_ok, m_data_ok;
  logic [31:0] m_rdata;
  logic [2:0]  out_cnt;
  logic        busy;

  typedef struct {
    logic        owner;
    logic [31:0] rdata;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp;
  int   n_bad;
  logic first_data;

  sram_port_arbiter #(.OUT_DEPTH(4), .CNT_W(3)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr),
    .inst_size(inst_size), .inst_wstrb(inst_wstrb),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr),
    .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size),
    .m_wstrb(m_wstrb), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok),
    .m_rdata(m_rdata),
    .out_cnt(out_cnt), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic idle();
    inst_req   = 0; inst_wr = 0; inst_size = 2'd2;
    inst_wstrb = 0; inst_addr = 0; inst_wdata = 0;
    data_req   = 0; data_wr = 0; data_size = 2'd2;
    data_wstrb = 0; data_addr = 0; data_wdata = 0;
    m_addr_ok  = 0; m_data_ok = 0; m_rdata = 0;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic rsp(input logic owner, input logic [31:0] rd);
    exp_t e;
    e.owner   = owner;
    e.rdata   = rd;
    sbq.push_back(e);
    m_data_ok = 1;
    m_rdata   = rd;
  endtask

  // Monitor: every response strobe pops one expected entry.
  always @(negedge clk) begin
    if (inst_data_ok || data_data_ok) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL resp_unexpected: inst %b data %b want none",
                 inst_data_ok, data_data_ok);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("resp_both", {31'd0, inst_data_ok & data_data_ok}, 0);
        chk("resp_owner", {31'd0, data_data_ok}, {31'd0, e.owner});
        chk("resp_rdata",
            data_data_ok ? data_rdata : inst_rdata, e.rdata);
      end
    end
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
`ifdef ARB_ROUND_ROBIN_EN
    first_data = 0;
`else
    first_data = 1;
`endif
    idle();
    resetn   = 0;
    inst_req = 1;
    m_rdata  = 32'hdeadbeef;
    @(posedge clk);
    mid();
    chk("rst_cnt", out_cnt, 0);
    chk("rst_mreq", m_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdata", inst_rdata, 0);
    idle();
    resetn = 1;
    adv();

    // single fetch
    inst_req = 1; inst_addr = 32'h1c000000; m_addr_ok = 1;
    mid();
    chk("f_addr_ok", inst_addr_ok, 1);
    chk("f_daddr_ok", data_addr_ok, 0);
    chk("f_maddr", m_addr, 32'h1c000000);
    chk("f_cnt0", out_cnt, 0);
    adv();
    idle();
    mid();
    chk("f_cnt1", out_cnt, 1);
    adv();
    rsp(0, 32'h02800000);
    mid();
    chk("f_cnt1b", out_cnt, 1);
    adv();
    idle();
    mid();
    chk("f_cnt2", out_cnt, 0);
    adv();

    // contention, preceded by a data accept
    data_req = 1; data_addr = 32'h200; m_addr_ok = 1;
    mid();
    chk("c_pre_ok", data_addr_ok, 1);
    adv();
    data_wr = 1; data_wstrb = 4'hf; data_addr = 32'h100;
    data_wdata = 32'ha5a5a5a5;
    inst_req = 1; inst_addr = 32'h1c000004;
    mid();
    chk("c1_addr", m_addr,
        first_data ? 32'h100 : 32'h1c000004);
    chk("c1_wr", m_wr, first_data);
    chk("c1_wstrb", m_wstrb, first_data ? 4'hf : 4'h0);
    chk("c1_dok", data_addr_ok, first_data);
    chk("c1_iok", inst_addr_ok, !first_data);
    adv();
    if (first_data) data_req = 0;
    else inst_req = 0;
    mid();
    chk("c2_addr", m_addr,
        first_data ? 32'h1c000004 : 32'h100);
    chk("c2_iok", inst_addr_ok, first_data);
    chk("c2_dok", data_addr_ok, !first_data);
    adv();
    idle();
    rsp(1, 32'h11111111);
    mid();
    chk("c_cnt3", out_cnt, 3);
    adv();
    idle();
    rsp(first_data, 32'h22222222);
    adv();
    idle();
    rsp(!first_data, 32'h33333333);
    adv();
    idle();
    mid();
    chk("c_cnt0", out_cnt, 0);
    adv();

    // lock
    data_req = 1; data_addr = 32'h300;
    mid();
    chk("l0_mreq", m_req, 1);
    chk("l0_addr", m_addr, 32'h300);
    chk("l0_dok", data_addr_ok, 0);
    adv();
    inst_req = 1; inst_addr = 32'h1c000008;
    for (int i = 0; i < 2; i++) begin
      mid();
      chk("l_addr", m_addr, 32'h300);
      chk("l_iok", inst_addr_ok, 0);
      chk("l_busy", busy, 1);
      chk("l_cnt", out_cnt, 0);
      adv();
    end
    m_addr_ok = 1;
    mid();
    chk("l_done_dok", data_addr_ok, 1);
    chk("l_done_iok", inst_addr_ok, 0);
    chk("l_done_addr", m_addr, 32'h300);
    adv();
    data_req = 0;
    mid();
    chk("l_inst_ok", inst_addr_ok, 1);
    chk("l_inst_addr", m_addr, 32'h1c000008);
    adv();
    idle();
    rsp(1, 32'h44444444);
    adv();
    idle();
    rsp(0, 32'h55555555);
    adv();
    idle();

    // full
    for (int i = 0; i < 4; i++) begin
      inst_req  = 1;
      inst_addr = 32'h1c000010 + 32'(4 * i);
      m_addr_ok = 1;
      mid();
      chk("u_fill_ok", inst_addr_ok, 1);
      adv();
    end
    inst_addr = 32'h1c000020;
    rsp(0, 32'h60000000);
    mid();
    chk("u_cnt4", out_cnt, 4);
    chk("u_mreq0", m_req, 0);
    chk("u_iok0", inst_addr_ok, 0);
    adv();
    m_data_ok = 0;
    mid();
    chk("u_cnt3", out_cnt, 3);
    chk("u_mreq1", m_req, 1);
    chk("u_iok1", inst_addr_ok, 1);
    adv();
    idle();
    mid();
    chk("u_cnt4b", out_cnt, 4);
    for (int i = 1; i <= 4; i++) begin
      adv();
      idle();
      rsp(0, 32'h60000000 + 32'(i));
    end
    adv();
    idle();
    mid();
    chk("u_cnt0", out_cnt, 0);
    adv();

    // ordering with simultaneous accept and response
    inst_req = 1; inst_addr = 32'h1c000030; m_addr_ok = 1;
    mid();
    chk("o1_iok", inst_addr_ok, 1);
    adv();
    inst_req = 0;
    data_req = 1; data_addr = 32'h400;
    rsp(0, 32'h70000001);
    mid();
    chk("o2_dok", data_addr_ok, 1);
    chk("o2_cnt", out_cnt, 1);
    adv();
    data_req = 0;
    inst_req = 1; inst_addr = 32'h1c000034;
    rsp(1, 32'h70000002);
    mid();
    chk("o3_iok", inst_addr_ok, 1);
    chk("o3_cnt", out_cnt, 1);
    adv();
    idle();
    rsp(0, 32'h70000003);
    mid();
    chk("o4_cnt", out_cnt, 1);
    adv();
    idle();
    mid();
    chk("o5_cnt", out_cnt, 0);
    adv();

    // async reset with outstanding work and a held lock
    for (int i = 0; i < 3; i++) begin
      inst_req  = 1;
      inst_addr = 32'h1c000040 + 32'(4 * i);
      m_addr_ok = 1;
      adv();
    end
    idle();
    data_req = 1; data_addr = 32'h500;
    mid();
    chk("r_mreq", m_req, 1);
    adv();
    chk("r_pre_cnt", out_cnt, 3);
    chk("r_pre_busy", busy, 1);
    #2;
    resetn = 0;
    #1;
    chk("r_cnt", out_cnt, 0);
    chk("r_mreq0", m_req, 0);
    chk("r_busy", busy, 0);
    idle();
    mid();
    resetn = 1;
    adv();
    m_data_ok = 1; m_rdata = 32'h00000bad;
    mid();
    chk("r_stray_d", data_data_ok, 0);
    chk("r_stray_i", inst_data_ok, 0);
    chk("r_stray_cnt", out_cnt, 0);
    adv();
    idle();
    adv();
    chk("sb_empty", 32'(sbq.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one SRAM-like memory port between the instruction-fetch requester (inst_sram_*) and the load/store requester (data_sram_*).
- Tracks in-order outstanding transactions, so each m_data_ok/m_rdata returns to the requester that issued it.
- Sits between the IF/MEM stages and the downstream SRAM-like-to-AXI bridge.

Parameters:
- OUT_DEPTH, 4: maximum outstanding accepted-but-unanswered transactions; power of 2, range 2..16.
- CNT_W, 3: width of out_cnt; must be at least log2(OUT_DEPTH)+1.

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- inst_req, inst_wr  in  1 each  instruction requester request and write flag.
- inst_size  in  2  transfer size.
- inst_wstrb  in  4  byte strobes.
- inst_addr, inst_wdata  in  32 each  address and write data.
- inst_addr_ok, inst_data_ok  out  1 each  address handshake and response strobe to the instruction requester.
- inst_rdata  out  32  read data to the instruction requester.
- data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata  in  1/1/2/4/32/32  data requester; same meaning as inst_*.
- data_addr_ok, data_data_ok  out  1 each  handshake and response strobe to the data requester.
- data_rdata  out  32  read data to the data requester.
- m_req, m_wr  out  1 each  downstream request and write flag.
- m_size  out  2  downstream transfer size.
- m_wstrb  out  4  downstream byte strobes.
- m_addr, m_wdata  out  32 each  downstream address and write data.
- m_addr_ok, m_data_ok  in  1 each  downstream address handshake and response strobe.
- m_rdata  in  32  downstream read data.
- out_cnt  out  CNT_W  number of outstanding transactions.
- busy  out  1  high when out_cnt != 0 or lock is held.

Behaviour:
- Reset (async assert, sync release): lock=0, FIFO empty, out_cnt=0, rr_last=0. All outputs are 0 during reset.
- full = (out_cnt == OUT_DEPTH), computed from registered state. A pop in the same cycle does not free a slot for a push.
- Arbitration (combinational, only when lock=0):
  - If data_req, grant data.
  - Else if inst_req, grant inst.
  - Data has fixed priority.
- Lock:
  - Set when m_req=1 and m_addr_ok=0; lock_id records the granted requester.
  - While lock=1, grant is forced to lock_id, regardless of the other requester.
  - Cleared on the cycle m_addr_ok=1.
  - If the locked requester drops req, lock clears next cycle and no transfer occurs. This protects the downstream port from mid-handshake changes.
- m_req = granted_req & ~full. m_wr, m_size, m_wstrb, m_addr, m_wdata mux from the granted requester, zero when nothing is granted.
- inst_addr_ok = m_addr_ok & m_req & (grant==inst). data_addr_ok is the same for the data requester. The loser always sees addr_ok=0.
- Accept = m_req & m_addr_ok: push the 1-bit owner id (0=inst, 1=data) into the ordered FIFO (depth OUT_DEPTH, wrap-around pointers). Write requests are tracked too, because the downstream returns data_ok for writes.
- Response = m_data_ok & (out_cnt!=0): pop the head.
  - inst_data_ok = Response & head==0; data_data_ok = Response & head==1.
  - inst_rdata and data_rdata both carry m_rdata unmasked. Consumers qualify with their own data_ok.
- Simultaneous accept and response: push and pop together; out_cnt unchanged.
- m_data_ok with FIFO empty: ignored. No strobe to either requester, out_cnt stays 0.
- Zero-latency paths: all outputs are combinational from inputs plus registered state. A response can return to a requester on the cycle after its accept, at the earliest.
- Cancellation is not handled here. Requesters discard stale responses themselves; the arbiter always routes every response.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- When defined: when both requests are present with lock=0, grant the requester not granted at the last accept (rr_last register, updated on each accept). A single requester is granted immediately.
- When undefined: fixed data priority as above; rr_last is absent.

Test Plan:
- Single fetch, reset then inst_req, addr 0x1c000000, m_addr_ok=1 same cycle, m_data_ok two cycles later with m_rdata 0x02800000:
  - inst_addr_ok=1 in the accept cycle.
  - inst_data_ok=1 with inst_rdata 0x02800000; data_data_ok=0.
  - out_cnt goes 0,1,0.
- Contention: inst_req and data_req (store, wstrb 0xF, addr 0x100) in the same cycle, m_addr_ok=1:
  - Without the macro, data is granted first and m_wr=1; inst is granted on the next cycle.
  - With ARB_ROUND_ROBIN_EN and the last accept=data, inst is granted first.
- Lock: data_req with m_addr_ok=0 for 3 cycles, then inst_req rises while the data handshake is pending:
  - m_addr stays on the data address until m_addr_ok.
  - inst_addr_ok stays 0 during lock.
- Full: issue 4 accepted reads with no m_data_ok:
  - out_cnt=4, a 5th request sees m_req=0.
  - An m_data_ok in the same cycle does not allow the 5th accept; it is accepted next cycle.
- Ordering: accept inst, data, inst back-to-back, then 3 m_data_ok pulses:
  - Strobes route inst, data, inst in that order.
  - Simultaneous accept+response keeps out_cnt constant.
- Async reset mid-operation: assert resetn=0 with out_cnt=3 and lock=1:
  - out_cnt=0 and m_req=0 immediately, without a clock edge.
  - A stray m_data_ok after release produces no data_ok.
